fp_normalize_round: RTL

//  Back end of the multi-precision accumulate datapath; the inverse of the pre-add alignment shift.
//  - Input: the 61-bit sign-magnitude sum, i.e. after two's-complement-to-magnitude conversion.
//  - Detects the leading one, normalizes, rounds to nearest-even and packs an IEEE-754 binary32.
//  - 3-stage valid/ready pipeline; sits between the accumulator adder and the PE result port.

---
 rtl/fp_normalize_round.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fp_normalize_round.sv
// Normalize / round-to-nearest-even / pack of a 61-bit sign-magnitude sum into binary32.
// Three-stage valid/ready pipeline; define FPNR_FLAGS_EN to add the out_flags port.
module fp_normalize_round #(
    parameter int W   = 61,
    parameter int EW  = 8,
    parameter int MW  = 23,
    parameter int PSW = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_mag,
    input  logic           in_sign,
    input  logic [EW-1:0]  in_exp,
    input  logic [PSW-1:0] in_pshift,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [EW+MW:0] out_fp
`ifdef FPNR_FLAGS_EN
    ,
    output logic [2:0]     out_flags
`endif
);
    localparam int PW   = $clog2(W);
    localparam int XW   = EW + 2;
    localparam int SW   = W - MW - 2;
    localparam int EMAX = (1 << EW) - 1;

    // stage advance chain: a stage loads when empty or when its content moves on
    logic w_s1_load;
    logic w_s2_load;
    logic w_s3_load;

    logic                 r_s1_valid;
    logic [W-1:0]         r_s1_mag;
    logic                 r_s1_sign;
    logic [PW-1:0]        r_s1_p;
    logic signed [XW-1:0] r_s1_e;

    logic                 r_s2_valid;
    logic                 r_s2_sign;
    logic                 r_s2_zero;
    logic signed [XW-1:0] r_s2_e;
    logic [MW-1:0]        r_s2_frac;
    logic                 r_s2_guard;
    logic                 r_s2_sticky;

    logic                 r_s3_valid;
    logic [EW+MW:0]       r_fp;

    assign w_s3_load = !r_s3_valid || out_ready;
    assign w_s2_load = !r_s2_valid || w_s3_load;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;
    assign out_valid = r_s3_valid;
    assign out_fp    = r_fp;

    // S1: leading-one position and unrounded exponent
    logic [PW-1:0]        w_p;
    logic signed [XW-1:0] w_e;

    always_comb begin
        w_p = '0;
        for (int i = 0; i < W; i++) begin
            if (in_mag[i]) w_p = PW'(i);
        end
    end

    assign w_e = XW'(in_exp) + XW'(w_p) - XW'(MW) - XW'(in_pshift);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
        end
        if (w_s1_load && in_valid) begin
            r_s1_mag  <= in_mag;
            r_s1_sign <= in_sign;
            r_s1_p    <= w_p;
            r_s1_e    <= w_e;
        end
    end

    // S2: lossless left shift puts the leading one at bit W-1
    logic [W-1:0] w_norm;

    assign w_norm = r_s1_mag << (PW'(W - 1) - r_s1_p);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
        end
        if (w_s2_load && r_s1_valid) begin
            r_s2_sign   <= r_s1_sign;
            r_s2_zero   <= !w_norm[W-1];
            r_s2_e      <= r_s1_e;
            r_s2_frac   <= w_norm[W-2 -: MW];
            r_s2_guard  <= w_norm[SW];
            r_s2_sticky <= |w_norm[SW-1:0];
        end
    end

    // S3: RNE increment; an all-ones fraction wraps to zero and bumps the exponent
    logic                 w_inc;
    logic                 w_carry;
    logic [MW-1:0]        w_frac;
    logic signed [XW-1:0] w_e_rnd;
    logic [EW+MW:0]       w_fp;

    assign w_inc   = r_s2_guard & (r_s2_sticky | r_s2_frac[0]);
    assign w_carry = w_inc & (&r_s2_frac);
    assign w_frac  = r_s2_frac + MW'(w_inc);
    assign w_e_rnd = r_s2_e + XW'(w_carry);

    always_comb begin
        w_fp = {r_s2_sign, w_e_rnd[EW-1:0], w_frac};
        if (r_s2_zero) begin
            w_fp = '0;
        end else if (int'(w_e_rnd) >= EMAX) begin
            w_fp = {r_s2_sign, {EW{1'b1}}, {MW{1'b0}}};
        end else if (int'(w_e_rnd) <= 0) begin
            w_fp = {r_s2_sign, {(EW+MW){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s3_valid <= 1'b0;
            r_fp       <= '0;
        end else if (w_s3_load) begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) r_fp <= w_fp;
        end
    end

`ifdef FPNR_FLAGS_EN
    logic [2:0] w_flags;
    logic [2:0] r_flags;

    always_comb begin
        w_flags = {2'b00, r_s2_guard | r_s2_sticky};
        if (r_s2_zero) begin
            w_flags = 3'b000;
        end else if (int'(w_e_rnd) >= EMAX) begin
            w_flags = 3'b100;
        end else if (int'(w_e_rnd) <= 0) begin
            w_flags = 3'b010;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= '0;
        end else if (w_s3_load && r_s2_valid) begin
            r_flags <= w_flags;
        end
    end

    assign out_flags = r_flags;
`endif

endmodule
